divider: RTL and testbench

- Iterative radix-2 non-restoring integer divider for the RV64M DIV/DIVU/REM/REMU and DIVW/DIVUW/REMW/REMUW instructions.
- Counterpart of the multi-cycle multiplier. Uses the same valid/ready/flush/out_valid handshake toward the EXU.
- Accepts one operation when idle and iterates one quotient bit per cycle.
- Presents the quotient and remainder with a one-cycle out_valid pulse.

---
 rtl/divider_if.sv | 26 ++
 rtl/divider.sv | 142 ++++++++++++++
 tb/tb_divider.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/divider_if.sv
// Request/response bundle between the EXU and the iterative divider.
// EXU side uses the master modport, the divider the slave modport.
interface divider_if #(
   parameter int XLEN = 64
);
   logic            div_valid;
   logic            flush;
   logic            divw;
   logic            div_signed;
   logic [XLEN-1:0] dividend;
   logic [XLEN-1:0] divisor;
   logic            div_ready;
   logic            out_valid;
   logic [XLEN-1:0] quotient;
   logic [XLEN-1:0] remainder;

   modport master (
      output div_valid, flush, divw, div_signed, dividend, divisor,
      input  div_ready, out_valid, quotient, remainder
   );

   modport slave (
      input  div_valid, flush, divw, div_signed, dividend, divisor,
      output div_ready, out_valid, quotient, remainder
   );
endinterface

// File: rtl/divider.sv
// Radix-2 non-restoring divider for RV64M DIV/DIVU/REM/REMU and their W forms.
// Fixed latency: one quotient bit per cycle, zero-divisor and overflow answered in one cycle.
module divider #(
   parameter int XLEN = 64
) (
   input  logic       clk,
   input  logic       rst,
   divider_if.slave   bus,
   output logic [1:0] dbg_state
);
   localparam int         HALF   = XLEN / 2;
   localparam logic [6:0] N_FULL = 7'(XLEN);
   localparam logic [6:0] N_HALF = 7'(HALF);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   state_t          state;
   logic [XLEN:0]   p_rem;
   logic [XLEN-1:0] q_sh;
   logic [XLEN-1:0] b_mag;
   logic [XLEN-1:0] quo_r;
   logic [XLEN-1:0] rem_r;
   logic            q_neg;
   logic            r_neg;
   logic            divw_q;
   logic [6:0]      cnt;
   logic [6:0]      n_lim;

   function automatic logic [XLEN-1:0] sext_half(input logic [XLEN-1:0] x);
      return {{(XLEN-HALF){x[HALF-1]}}, x[HALF-1:0]};
   endfunction

   function automatic logic [XLEN-1:0] zext_half(input logic [XLEN-1:0] x);
      return {{(XLEN-HALF){1'b0}}, x[HALF-1:0]};
   endfunction

   // Handshake: an op is taken on a clock edge where div_valid & div_ready & ~flush;
   // div_ready is high only in IDLE, and out_valid is a single-cycle pulse in DONE
   // unless flush is asserted in that same cycle.
   logic            accept;
   logic [XLEN-1:0] a_ext, b_ext, a_abs, b_abs, min_neg;
   logic [XLEN-1:0] spec_q, spec_r;
   logic            a_sgn, b_sgn, div_zero, ovf;

   always_comb begin
      a_ext   = bus.dividend;
      b_ext   = bus.divisor;
      min_neg = {1'b1, {(XLEN-1){1'b0}}};
      if (bus.divw) begin
         a_ext   = bus.div_signed ? sext_half(bus.dividend) : zext_half(bus.dividend);
         b_ext   = bus.div_signed ? sext_half(bus.divisor)  : zext_half(bus.divisor);
         min_neg = {{(XLEN-HALF+1){1'b1}}, {(HALF-1){1'b0}}};
      end
      a_sgn    = bus.div_signed & a_ext[XLEN-1];
      b_sgn    = bus.div_signed & b_ext[XLEN-1];
      a_abs    = a_sgn ? -a_ext : a_ext;
      b_abs    = b_sgn ? -b_ext : b_ext;
      div_zero = (b_ext == '0);
      ovf      = bus.div_signed & (a_ext == min_neg) & (&b_ext);
      spec_q   = '1;
      spec_r   = bus.divw ? sext_half(bus.dividend) : bus.dividend;
      if (!div_zero) begin
         spec_q = spec_r;
         spec_r = '0;
      end
      accept   = bus.div_valid & (state == IDLE) & ~bus.flush;
   end

   // One iteration, plus the final remainder restore and sign fix used on the last edge.
   logic [XLEN:0]   p_sh, p_nxt;
   logic [XLEN-1:0] q_nxt, r_mag, q_s, r_s, q_res, r_res;

   always_comb begin
      p_sh  = {p_rem[XLEN-1:0], q_sh[XLEN-1]};
      p_nxt = p_rem[XLEN] ? p_sh + {1'b0, b_mag} : p_sh - {1'b0, b_mag};
      q_nxt = {q_sh[XLEN-2:0], ~p_nxt[XLEN]};
      r_mag = p_nxt[XLEN] ? p_nxt[XLEN-1:0] + b_mag : p_nxt[XLEN-1:0];
      q_s   = q_neg ? -q_nxt : q_nxt;
      r_s   = r_neg ? -r_mag : r_mag;
      q_res = divw_q ? sext_half(q_s) : q_s;
      r_res = divw_q ? sext_half(r_s) : r_s;
      n_lim = divw_q ? N_HALF : N_FULL;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         p_rem  <= '0;
         q_sh   <= '0;
         b_mag  <= '0;
         quo_r  <= '0;
         rem_r  <= '0;
         q_neg  <= 1'b0;
         r_neg  <= 1'b0;
         divw_q <= 1'b0;
         cnt    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  divw_q <= bus.divw;
                  q_neg  <= a_sgn ^ b_sgn;
                  r_neg  <= a_sgn;
                  p_rem  <= '0;
                  q_sh   <= bus.divw ? (a_abs << HALF) : a_abs;
                  b_mag  <= b_abs;
                  cnt    <= '0;
                  if (div_zero || ovf) begin
                     quo_r <= spec_q;
                     rem_r <= spec_r;
                     state <= DONE;
                  end else begin
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               if (bus.flush) begin
                  state <= IDLE;
               end else begin
                  p_rem <= p_nxt;
                  q_sh  <= q_nxt;
                  cnt   <= (cnt == n_lim) ? cnt : cnt + 7'd1;
                  if (cnt == n_lim - 7'd1) begin
                     quo_r <= q_res;
                     rem_r <= r_res;
                     state <= DONE;
                  end
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.div_ready = (state == IDLE);
   assign bus.out_valid = (state == DONE) & ~bus.flush;
   assign bus.quotient  = quo_r;
   assign bus.remainder = rem_r;
   assign dbg_state     = state;
endmodule

// File: tb/tb_divider.sv
// Directed bench for divider: hand-computed quotient/remainder vectors, latency,
// special cases, flush and reset aborts.
module tb_divider;
   logic        clk;
   logic        rst;
   logic [1:0]  dbg_state;
   int          n_cmp;
   int          n_err;
   logic [63:0] exp_q[$];

   divider_if #(.XLEN(64)) bus ();

   divider #(.XLEN(64)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   // Clock and reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.div_valid  = 1'b0;
      bus.flush      = 1'b0;
      bus.divw       = 1'b0;
      bus.div_signed = 1'b0;
      bus.dividend   = '0;
      bus.divisor    = '0;
   endtask

   // Driver + scoreboard: issue one op, wait for out_valid, compare against exp_q.
   task automatic do_op(input string tag, input logic w, input logic s,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] eq, input logic [63:0] er, input int lat);
      int          k;
      bit          seen;
      bit          busy_bad;
      logic [63:0] xq, xr;
      @(posedge clk); #1;
      check({tag, "/ready"}, 64'(bus.div_ready), 64'd1);
      bus.div_valid  = 1'b1;
      bus.divw       = w;
      bus.div_signed = s;
      bus.dividend   = a;
      bus.divisor    = b;
      exp_q.push_back(eq);
      exp_q.push_back(er);
      @(posedge clk); #1;
      idle_inputs();
      k        = 1;
      seen     = 1'b0;
      busy_bad = 1'b0;
      while (!seen && k <= 200) begin
         @(negedge clk);
         if (bus.out_valid) begin
            seen = 1'b1;
         end else begin
            busy_bad = busy_bad | bus.div_ready;
            @(posedge clk);
            k++;
         end
      end
      xq = exp_q.pop_front();
      xr = exp_q.pop_front();
      check({tag, "/out_valid_seen"}, 64'(seen), 64'd1);
      if (seen) begin
         check({tag, "/latency"}, 64'(k), 64'(lat));
         check({tag, "/busy_not_ready"}, 64'(busy_bad), 64'd0);
         check({tag, "/quotient"}, bus.quotient, xq);
         check({tag, "/remainder"}, bus.remainder, xr);
         @(posedge clk);
         @(negedge clk);
         check({tag, "/single_pulse"}, 64'(bus.out_valid), 64'd0);
         check({tag, "/ready_after"}, 64'(bus.div_ready), 64'd1);
         check({tag, "/quotient_held"}, bus.quotient, xq);
      end
   endtask

   // Start a 100/7 op and kill it in RUN cycle 10 with flush or rst.
   task automatic abort_op(input string tag, input bit use_rst);
      bit seen;
      @(posedge clk); #1;
      bus.div_valid = 1'b1;
      bus.dividend  = 64'd100;
      bus.divisor   = 64'd7;
      @(posedge clk); #1;
      idle_inputs();
      for (int i = 1; i < 10; i++) begin
         @(posedge clk); #1;
      end
      if (use_rst) rst = 1'b1;
      else bus.flush = 1'b1;
      @(posedge clk); #1;
      rst       = 1'b0;
      bus.flush = 1'b0;
      @(negedge clk);
      check({tag, "/ready_next"}, 64'(bus.div_ready), 64'd1);
      check({tag, "/state_idle"}, 64'(dbg_state), 64'd0);
      if (use_rst) begin
         check({tag, "/quotient_reset"}, bus.quotient, 64'd0);
         check({tag, "/remainder_reset"}, bus.remainder, 64'd0);
      end
      seen = 1'b0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         seen = seen | bus.out_valid;
      end
      check({tag, "/no_out_valid"}, 64'(seen), 64'd0);
   endtask

   initial begin
      bit seen;
      n_cmp = 0;
      n_err = 0;
      idle_inputs();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset/ready", 64'(bus.div_ready), 64'd1);
      check("reset/out_valid", 64'(bus.out_valid), 64'd0);
      check("reset/quotient", bus.quotient, 64'd0);
      check("reset/remainder", bus.remainder, 64'd0);
      check("reset/state", 64'(dbg_state), 64'd0);

      do_op("divu_100_7", 1'b0, 1'b0, 64'd100, 64'd7, 64'd14, 64'd2, 65);
      do_op("div_m7_2", 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
            64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 65);
      do_op("div_7_m2", 1'b0, 1'b1, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE,
            64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 65);
      do_op("divu_big", 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'h8000_0000_0000_0000,
            64'd1, 64'h7FFF_FFFF_FFFF_FFFE, 65);
      do_op("divu_max_1", 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,
            64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 65);
      do_op("div_zero_s", 1'b0, 1'b1, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 1);
      do_op("div_zero_u", 1'b0, 1'b0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 1);
      do_op("div_ovf", 1'b0, 1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
            64'h8000_0000_0000_0000, 64'd0, 1);
      do_op("divw_s", 1'b1, 1'b1, 64'h0000_0001_8000_0000, 64'd1,
            64'hFFFF_FFFF_8000_0000, 64'd0, 33);
      do_op("divuw", 1'b1, 1'b0, 64'h0000_0000_FFFF_FFFF, 64'd2,
            64'h0000_0000_7FFF_FFFF, 64'd1, 33);
      do_op("divuw_zero", 1'b1, 1'b0, 64'h0000_0000_8000_0001, 64'hFFFF_FFFF_0000_0000,
            64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0001, 1);
      do_op("divw_ovf", 1'b1, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
            64'hFFFF_FFFF_8000_0000, 64'd0, 1);

      // flush together with div_valid in IDLE must not start anything
      @(posedge clk); #1;
      bus.div_valid = 1'b1;
      bus.flush     = 1'b1;
      bus.dividend  = 64'd50;
      bus.divisor   = 64'd5;
      @(posedge clk); #1;
      idle_inputs();
      @(negedge clk);
      check("idle_flush/state", 64'(dbg_state), 64'd0);
      check("idle_flush/ready", 64'(bus.div_ready), 64'd1);
      check("idle_flush/out_valid", 64'(bus.out_valid), 64'd0);

      abort_op("flush_run", 1'b0);
      do_op("after_flush_9_3", 1'b0, 1'b0, 64'd9, 64'd3, 64'd3, 64'd0, 65);
      abort_op("rst_run", 1'b1);
      do_op("after_rst_9_3", 1'b0, 1'b0, 64'd9, 64'd3, 64'd3, 64'd0, 65);

      // flush in DONE suppresses the pulse of a special-case op
      @(posedge clk); #1;
      bus.div_valid = 1'b1;
      bus.dividend  = 64'h55;
      bus.divisor   = 64'd0;
      @(posedge clk); #1;
      idle_inputs();
      bus.flush = 1'b1;
      @(negedge clk);
      check("done_flush/out_valid", 64'(bus.out_valid), 64'd0);
      @(posedge clk); #1;
      bus.flush = 1'b0;
      @(negedge clk);
      check("done_flush/ready", 64'(bus.div_ready), 64'd1);
      seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         seen = seen | bus.out_valid;
      end
      check("done_flush/no_late_pulse", 64'(seen), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
